aes_add_rk_stream: RTL and testbench
====================================

# aes_add_rk_stream

Streaming, parametrised successor to the combinational add-round-key stage. It buffers one full round key of `NUM_WORDS` words of `DATA_W` bits, then XORs a stream of state words against the matching key words. Each word goes through a registered valid/ready output stage. The block sits between the MixColumns/ShiftRows datapath and the round register. It replaces the tristate select with a real 2:1 mux, and adds per-word key bypass, key reuse, and block-boundary tagging.

## Interface
- `DATA_W`, 32: width of one state/key word; legal values 8, 32, 64, 128.
- `NUM_WORDS`, 4: words per round key/state block; must be ≥ 2. `CNT_W` = clog2(`NUM_WORDS`).

- `ARKS_I_CLK`, input, 1: clock; all state updates on the rising edge.
- `ARKS_I_RST_N`, input, 1: reset, asynchronous, active-low.
- `ARKS_I_KEY_VALID`, input, 1: key word offered.
- `ARKS_O_KEY_READY`, output, 1: key word accepted this cycle when high together with valid.
- `ARKS_I_KEY_IN`, input, `DATA_W`: key word, loaded in index order 0..`NUM_WORDS`-1.
- `ARKS_I_VALID`, input, 1: state word offered.
- `ARKS_O_READY`, output, 1: state word accepted when high together with valid.
- `ARKS_I_MIX_ACTIVE`, input, 1: 1 selects `ARKS_I_DATAIN` (MixColumns output); 0 selects `ARKS_I_ALT_IN` (final-round path).
- `ARKS_I_DATAIN`, input, `DATA_W`: MixColumns word.
- `ARKS_I_ALT_IN`, input, `DATA_W`: ShiftRows word used when MixColumns is inactive.
- `ARKS_I_B0`, input, 1: per-word bypass; 1 passes the selected word unmodified.
- `ARKS_I_KEY_HOLD`, input, 1: sampled with the last word of a block; 1 retains the key for the next block.
- `ARKS_O_VALID`, output, 1: output word valid.
- `ARKS_I_OUT_READY`, input, 1: downstream accept.
- `ARKS_O_DATA`, output, `DATA_W`: result word.
- `ARKS_O_LAST`, output, 1: output word is word index `NUM_WORDS`-1 of its block.

## Operation
- **State machine:** two states, `S_KEY` and `S_RUN`. Reset state is `S_KEY`.
- **`S_KEY`:**
  - `ARKS_O_KEY_READY` = 1 and `ARKS_O_READY` = 0.
  - Each key handshake writes `key_mem[kcnt]` and increments `kcnt`.
  - The handshake at `kcnt` = `NUM_WORDS`-1 wraps `kcnt` to 0 and moves to `S_RUN` next cycle.
- **`S_RUN`:**
  - `ARKS_O_KEY_READY` = 0. Key valid is ignored and the key contents are unchanged.
  - `ARKS_O_READY` = !`ARKS_O_VALID` | `ARKS_I_OUT_READY`.
- **Data path per accepted word:**
  - sel = `ARKS_I_MIX_ACTIVE` ? `ARKS_I_DATAIN` : `ARKS_I_ALT_IN`.
  - result = `ARKS_I_B0` ? sel : sel ^ `key_mem[dcnt]`.
  - result is registered into `ARKS_O_DATA`. `ARKS_O_LAST` is set when `dcnt` = `NUM_WORDS`-1, and `dcnt` increments.
- **Bypass:** `dcnt` advances on bypassed words exactly as on keyed words.
- **End of block:** on acceptance of word `NUM_WORDS`-1, `dcnt` wraps to 0.
  - If `ARKS_I_KEY_HOLD` = 1, stay in `S_RUN`.
  - Otherwise go to `S_KEY`. Words already in the output register still drain normally.
- **Output register:** loads on input handshake. Valid clears when `ARKS_I_OUT_READY` = 1 and no new word is accepted. With no downstream accept, the held word, valid and last flag stay stable.

## Timing
- **Reset values:** `ARKS_O_VALID` = 0, `ARKS_O_DATA` = 0, `ARKS_O_LAST` = 0, `ARKS_O_KEY_READY` = 1, `ARKS_O_READY` = 0. `kcnt` = `dcnt` = 0, state = `S_KEY`, every `key_mem` word = 0.
- **Reset mid-operation:** asserting reset during a key load or a block discards the partial key and the in-flight output immediately. After release, a full key load is required.
- **Key load:** `NUM_WORDS` cycles minimum. The first data word can be accepted in the cycle after the last key handshake.
- **Latency:** 1 cycle from input handshake to `ARKS_O_VALID`.
- **Throughput:** 1 word/cycle sustained while `ARKS_I_OUT_READY` = 1, including across held-key block boundaries.
- **Returning to `S_KEY` without hold:** no bubble is inserted before key reload. Key-ready rises the cycle after the last data handshake.
- **Outputs are registered:** `ARKS_O_DATA`, `ARKS_O_VALID`, `ARKS_O_LAST`.
- **Combinational readies:** `ARKS_O_READY` depends combinationally on `ARKS_I_OUT_READY`. `ARKS_O_KEY_READY` is a pure state decode.
- **Control sampling:** mux select, bypass and hold are sampled only on a data handshake and are ignored otherwise.

## Test plan
- **Basic keyed block:** reset; load key words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F; send DATAIN 0xFFFFFFFF ×4 with MIX_ACTIVE = 1, B0 = 0, OUT_READY = 1.
  - Outputs must be 0xFFFEFDFC, 0xFBFAF9F8, 0xF7F6F5F4, 0xF3F2F1F0, each 1 cycle after input.
  - LAST must be high only on the 4th output; KEY_READY must be high the cycle after the 4th accept.
- **Mux and bypass:** same key; send MIX_ACTIVE = 0 with ALT_IN 0x11111111 and B0 = 1 on word 1 only.
  - Word 0 must be 0x11101312; word 1 must be 0x11111111.
  - Word 2 must use key word 2, giving 0x19181B1A.
- **Backpressure:** hold OUT_READY = 0 for 3 cycles with one word in the output register.
  - READY must be 0; DATA, VALID and LAST must be stable.
  - Upon OUT_READY = 1, the next word must be accepted in the same cycle with no word lost or duplicated.
- **Key hold:** KEY_HOLD = 1 on word 3, then a second block of 4 words.
  - No key load may occur; second-block results must match the first key; throughput must be 8 words in 8 cycles.
- **Key port during run:** drive KEY_VALID with 0xDEADBEEF throughout `S_RUN`.
  - KEY_READY must be 0 and outputs must still use the original key.
- **Mid-block reset:** assert RST_N low after 2 key words, or after 2 data words.
  - All outputs must take reset values immediately; after release, 4 key handshakes are needed before READY = 1.

Source files
------------

// File: rtl/aes_add_rk_stream.sv
// aes_add_rk_stream: streaming add-round-key stage.
// Buffers one round key of NUM_WORDS words of DATA_W bits, then XORs each
// accepted state word with the key word at the same index. The result is
// registered into a valid/ready output stage.
// Ports:
//   ARKS_I_CLK, ARKS_I_RST_N            clock, async active-low reset
//   ARKS_I_KEY_VALID/ARKS_O_KEY_READY   key word handshake, ARKS_I_KEY_IN data
//   ARKS_I_VALID/ARKS_O_READY            state word handshake
//   ARKS_I_MIX_ACTIVE                    1: ARKS_I_DATAIN, 0: ARKS_I_ALT_IN
//   ARKS_I_B0                            per-word key bypass
//   ARKS_I_KEY_HOLD                      keep key after the last word of a block
//   ARKS_O_VALID/ARKS_I_OUT_READY        output handshake
//   ARKS_O_DATA, ARKS_O_LAST             result word, last-word-of-block flag
module aes_add_rk_stream #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic              ARKS_I_CLK,
  input  logic              ARKS_I_RST_N,
  input  logic              ARKS_I_KEY_VALID,
  output logic              ARKS_O_KEY_READY,
  input  logic [DATA_W-1:0] ARKS_I_KEY_IN,
  input  logic              ARKS_I_VALID,
  output logic              ARKS_O_READY,
  input  logic              ARKS_I_MIX_ACTIVE,
  input  logic [DATA_W-1:0] ARKS_I_DATAIN,
  input  logic [DATA_W-1:0] ARKS_I_ALT_IN,
  input  logic              ARKS_I_B0,
  input  logic              ARKS_I_KEY_HOLD,
  output logic              ARKS_O_VALID,
  input  logic              ARKS_I_OUT_READY,
  output logic [DATA_W-1:0] ARKS_O_DATA,
  output logic              ARKS_O_LAST
);

  localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    S_KEY = 1'b0,
    S_RUN = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_kcnt;
  logic [CNT_W-1:0]  r_dcnt;
  logic [DATA_W-1:0] r_key_mem [NUM_WORDS];
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  logic              w_key_hs;
  logic              w_in_hs;
  logic              w_key_last;
  logic              w_data_last;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_result;

  assign w_key_hs    = ARKS_I_KEY_VALID & ARKS_O_KEY_READY;
  assign w_in_hs     = ARKS_I_VALID & ARKS_O_READY;
  assign w_key_last  = (r_kcnt == LAST_IDX);
  assign w_data_last = (r_dcnt == LAST_IDX);

  // State register
  always_ff @(posedge ARKS_I_CLK or negedge ARKS_I_RST_N) begin
    if (!ARKS_I_RST_N) begin
      r_state <= S_KEY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: leave S_KEY on the last key word, leave S_RUN on the last
  // data word unless the key is held for another block.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_KEY: if (w_key_hs && w_key_last) w_state_nxt = S_RUN;
      S_RUN: if (w_in_hs && w_data_last && !ARKS_I_KEY_HOLD) w_state_nxt = S_KEY;
      default: w_state_nxt = S_KEY;
    endcase
  end

  // Handshake readies: key-ready is a state decode, data ready lets a new
  // word in whenever the output slot is empty or draining this cycle.
  always_comb begin
    ARKS_O_KEY_READY = 1'b0;
    ARKS_O_READY     = 1'b0;
    case (r_state)
      S_KEY: ARKS_O_KEY_READY = 1'b1;
      S_RUN: ARKS_O_READY     = !r_valid || ARKS_I_OUT_READY;
      default: ARKS_O_KEY_READY = 1'b0;
    endcase
  end

  // Key word counter
  always_ff @(posedge ARKS_I_CLK or negedge ARKS_I_RST_N) begin
    if (!ARKS_I_RST_N) begin
      r_kcnt <= '0;
    end else if (w_key_hs) begin
      r_kcnt <= w_key_last ? '0 : r_kcnt + CNT_W'(1);
    end
  end

  // Round key storage
  always_ff @(posedge ARKS_I_CLK or negedge ARKS_I_RST_N) begin
    if (!ARKS_I_RST_N) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        r_key_mem[i] <= '0;
      end
    end else if (w_key_hs) begin
      r_key_mem[r_kcnt] <= ARKS_I_KEY_IN;
    end
  end

  // Data word counter; bypassed words advance it like keyed words
  always_ff @(posedge ARKS_I_CLK or negedge ARKS_I_RST_N) begin
    if (!ARKS_I_RST_N) begin
      r_dcnt <= '0;
    end else if (w_in_hs) begin
      r_dcnt <= w_data_last ? '0 : r_dcnt + CNT_W'(1);
    end
  end

  assign w_sel    = ARKS_I_MIX_ACTIVE ? ARKS_I_DATAIN : ARKS_I_ALT_IN;
  assign w_result = ARKS_I_B0 ? w_sel : (w_sel ^ r_key_mem[r_dcnt]);

  // Output stage: data and last only change on a new word
  always_ff @(posedge ARKS_I_CLK or negedge ARKS_I_RST_N) begin
    if (!ARKS_I_RST_N) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (w_in_hs) begin
      r_valid <= 1'b1;
      r_data  <= w_result;
      r_last  <= w_data_last;
    end else if (ARKS_I_OUT_READY) begin
      r_valid <= 1'b0;
    end
  end

  assign ARKS_O_VALID = r_valid;
  assign ARKS_O_DATA  = r_data;
  assign ARKS_O_LAST  = r_last;

endmodule

// File: tb/tb_aes_add_rk_stream.sv
// Directed bench for aes_add_rk_stream (DATA_W=32, NUM_WORDS=4).
// Inputs change on the falling edge; outputs are read on the next falling
// edge, combinational readies 1 time unit after the inputs change.
module tb_aes_add_rk_stream;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] key_in;
  logic        valid;
  logic        ready;
  logic        mix;
  logic [31:0] datain;
  logic [31:0] altin;
  logic        b0;
  logic        hold;
  logic        o_valid;
  logic        out_ready;
  logic [31:0] o_data;
  logic        o_last;

  int n_pass;
  int n_total;
  logic [31:0] kw [4];

  aes_add_rk_stream #(.DATA_W(32), .NUM_WORDS(4)) dut (
    .ARKS_I_CLK        (clk),
    .ARKS_I_RST_N      (rst_n),
    .ARKS_I_KEY_VALID  (key_valid),
    .ARKS_O_KEY_READY  (key_ready),
    .ARKS_I_KEY_IN     (key_in),
    .ARKS_I_VALID      (valid),
    .ARKS_O_READY      (ready),
    .ARKS_I_MIX_ACTIVE (mix),
    .ARKS_I_DATAIN     (datain),
    .ARKS_I_ALT_IN     (altin),
    .ARKS_I_B0         (b0),
    .ARKS_I_KEY_HOLD   (hold),
    .ARKS_O_VALID      (o_valid),
    .ARKS_I_OUT_READY  (out_ready),
    .ARKS_O_DATA       (o_data),
    .ARKS_O_LAST       (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    key_valid = 1'b0; key_in = 32'h0; valid = 1'b0; mix = 1'b1;
    datain = 32'h0; altin = 32'h0; b0 = 1'b0; hold = 1'b0; out_ready = 1'b1;
  endtask

  // Loads kw[0..3]; starts and ends on a falling edge.
  task automatic load_key();
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1;
      key_in    = kw[i];
      @(negedge clk);
    end
    key_valid = 1'b0;
  endtask

  task automatic drain();
    valid = 1'b0; hold = 1'b0; b0 = 1'b0; out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid); else n_pass++;
    n_total++; if (o_data !== 32'h0) $display("FAIL reset_data got %h exp 00000000", o_data); else n_pass++;
    n_total++; if (o_last !== 1'b0) $display("FAIL reset_last got %b exp 0", o_last); else n_pass++;
    n_total++; if (key_ready !== 1'b1) $display("FAIL reset_key_ready got %b exp 1", key_ready); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] exp [4];
    exp = '{32'hFFFEFDFC, 32'hFBFAF9F8, 32'hF7F6F5F4, 32'hF3F2F1F0};
    load_key();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; mix = 1'b1; datain = 32'hFFFFFFFF; altin = 32'h0;
      b0 = 1'b0; hold = 1'b0; out_ready = 1'b1;
      #1;
      n_total++; if (ready !== 1'b1) $display("FAIL basic_ready[%0d] got %b exp 1", i, ready); else n_pass++;
      @(negedge clk);
      n_total++; if (o_valid !== 1'b1) $display("FAIL basic_valid[%0d] got %b exp 1", i, o_valid); else n_pass++;
      n_total++; if (o_data !== exp[i]) $display("FAIL basic_data[%0d] got %h exp %h", i, o_data, exp[i]); else n_pass++;
      n_total++; if (o_last !== (i == 3)) $display("FAIL basic_last[%0d] got %b exp %b", i, o_last, (i == 3)); else n_pass++;
    end
    valid = 1'b0;
    #1;
    n_total++; if (key_ready !== 1'b1) $display("FAIL basic_key_ready_after got %b exp 1", key_ready); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL basic_ready_after got %b exp 0", ready); else n_pass++;
    @(negedge clk);
    n_total++; if (o_valid !== 1'b0) $display("FAIL basic_valid_drained got %b exp 0", o_valid); else n_pass++;
  endtask

  task automatic test_mux_bypass();
    logic [31:0] exp [4];
    exp = '{32'h11101312, 32'h11111111, 32'h19181B1A, 32'h1D1C1F1E};
    load_key();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; mix = 1'b0; datain = 32'hFFFFFFFF; altin = 32'h11111111;
      b0 = (i == 1); hold = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_total++; if (o_data !== exp[i]) $display("FAIL mux_data[%0d] got %h exp %h", i, o_data, exp[i]); else n_pass++;
      n_total++; if (o_last !== (i == 3)) $display("FAIL mux_last[%0d] got %b exp %b", i, o_last, (i == 3)); else n_pass++;
    end
    drain();
  endtask

  task automatic test_backpressure();
    load_key();
    valid = 1'b1; mix = 1'b1; datain = 32'hA0A0A0A0; b0 = 1'b0; hold = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (o_data !== 32'hA0A1A2A3) $display("FAIL bp_data0 got %h exp a0a1a2a3", o_data); else n_pass++;
    datain = 32'hB0B0B0B0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_total++; if (ready !== 1'b0) $display("FAIL bp_ready_stall[%0d] got %b exp 0", c, ready); else n_pass++;
      @(negedge clk);
      n_total++; if (o_data !== 32'hA0A1A2A3) $display("FAIL bp_data_stall[%0d] got %h exp a0a1a2a3", c, o_data); else n_pass++;
      n_total++; if (o_valid !== 1'b1) $display("FAIL bp_valid_stall[%0d] got %b exp 1", c, o_valid); else n_pass++;
      n_total++; if (o_last !== 1'b0) $display("FAIL bp_last_stall[%0d] got %b exp 0", c, o_last); else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL bp_ready_release got %b exp 1", ready); else n_pass++;
    @(negedge clk);
    n_total++; if (o_data !== 32'hB4B5B6B7) $display("FAIL bp_data1 got %h exp b4b5b6b7", o_data); else n_pass++;
    n_total++; if (o_valid !== 1'b1) $display("FAIL bp_valid1 got %b exp 1", o_valid); else n_pass++;
    datain = 32'hC0C0C0C0;
    @(negedge clk);
    n_total++; if (o_data !== 32'hC8C9CACB) $display("FAIL bp_data2 got %h exp c8c9cacb", o_data); else n_pass++;
    datain = 32'hD0D0D0D0;
    @(negedge clk);
    n_total++; if (o_data !== 32'hDCDDDEDF) $display("FAIL bp_data3 got %h exp dcdddedf", o_data); else n_pass++;
    n_total++; if (o_last !== 1'b1) $display("FAIL bp_last3 got %b exp 1", o_last); else n_pass++;
    drain();
  endtask

  task automatic test_key_port_run();
    logic [31:0] exp [4];
    exp = '{32'h1235547B, 32'h1631507F, 32'h1A3D5C73, 32'h1E395877};
    load_key();
    key_valid = 1'b1; key_in = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; mix = 1'b1; datain = 32'h12345678; b0 = 1'b0; hold = 1'b0; out_ready = 1'b1;
      #1;
      n_total++; if (key_ready !== 1'b0) $display("FAIL kp_key_ready[%0d] got %b exp 0", i, key_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (o_data !== exp[i]) $display("FAIL kp_data[%0d] got %h exp %h", i, o_data, exp[i]); else n_pass++;
    end
    key_valid = 1'b0;
    drain();
  endtask

  task automatic test_key_hold();
    logic [31:0] exp [8];
    exp = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
            32'hFFFEFDFC, 32'hFBFAF9F8, 32'hF7F6F5F4, 32'hF3F2F1F0};
    load_key();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; mix = 1'b1; datain = (i < 4) ? 32'h0 : 32'hFFFFFFFF;
      b0 = 1'b0; hold = (i == 3); out_ready = 1'b1;
      #1;
      n_total++; if (ready !== 1'b1) $display("FAIL hold_ready[%0d] got %b exp 1", i, ready); else n_pass++;
      n_total++; if (key_ready !== 1'b0) $display("FAIL hold_key_ready[%0d] got %b exp 0", i, key_ready); else n_pass++;
      @(negedge clk);
      n_total++; if (o_data !== exp[i]) $display("FAIL hold_data[%0d] got %h exp %h", i, o_data, exp[i]); else n_pass++;
      n_total++; if (o_last !== ((i % 4) == 3)) $display("FAIL hold_last[%0d] got %b exp %b", i, o_last, ((i % 4) == 3)); else n_pass++;
    end
    valid = 1'b0; hold = 1'b0;
    #1;
    n_total++; if (key_ready !== 1'b1) $display("FAIL hold_key_ready_end got %b exp 1", key_ready); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    // Reset during a partial key load
    for (int i = 0; i < 2; i++) begin
      key_valid = 1'b1; key_in = 32'hFFFFFFFF;
      @(negedge clk);
    end
    key_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (key_ready !== 1'b1) $display("FAIL rk_key_ready got %b exp 1", key_ready); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rk_ready got %b exp 0", ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_in = kw[i];
      #1;
      n_total++; if (ready !== 1'b0) $display("FAIL rk_ready_load[%0d] got %b exp 0", i, ready); else n_pass++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    #1;
    n_total++; if (ready !== 1'b1) $display("FAIL rk_ready_loaded got %b exp 1", ready); else n_pass++;
    // Two data words, then reset with a word in the output register
    valid = 1'b1; mix = 1'b1; datain = 32'h0; b0 = 1'b0; hold = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (o_data !== 32'h00010203) $display("FAIL rk_data0 got %h exp 00010203", o_data); else n_pass++;
    @(negedge clk);
    n_total++; if (o_data !== 32'h04050607) $display("FAIL rk_data1 got %h exp 04050607", o_data); else n_pass++;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (o_valid !== 1'b0) $display("FAIL rd_valid got %b exp 0", o_valid); else n_pass++;
    n_total++; if (o_data !== 32'h0) $display("FAIL rd_data got %h exp 00000000", o_data); else n_pass++;
    n_total++; if (o_last !== 1'b0) $display("FAIL rd_last got %b exp 0", o_last); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL rd_ready got %b exp 0", ready); else n_pass++;
    n_total++; if (key_ready !== 1'b1) $display("FAIL rd_key_ready got %b exp 1", key_ready); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++; if (ready !== 1'b0) $display("FAIL rd_ready_after got %b exp 0", ready); else n_pass++;
    load_key();
    for (int i = 0; i < 4; i++) begin
      valid = 1'b1; mix = 1'b1; datain = 32'h0; b0 = 1'b0; hold = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_total++; if (o_data !== kw[i]) $display("FAIL rd_data_reload[%0d] got %h exp %h", i, o_data, kw[i]); else n_pass++;
      n_total++; if (o_last !== (i == 3)) $display("FAIL rd_last_reload[%0d] got %b exp %b", i, o_last, (i == 3)); else n_pass++;
    end
    drain();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    kw[0] = 32'h00010203;
    kw[1] = 32'h04050607;
    kw[2] = 32'h08090A0B;
    kw[3] = 32'h0C0D0E0F;
    test_reset();
    test_basic();
    test_mux_bypass();
    test_backpressure();
    test_key_port_run();
    test_key_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
